// File: rtl/flip_pkg.sv
// Shared types and defaults for the flip decision and flipping blocks.
// Holds the FSM state enum and the count-width helper.
package flip_pkg;

    localparam int unsigned DefN        = 16;
    localparam int unsigned DefM        = 16;
    localparam int unsigned DefPatchCap = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/flip_decision_unit_if.sv
// Block-in / decision-out bus of flip_decision_unit.
// resid and uncorrectable exist only with FLIP_DECISION_PATCH_COUNT_EN.
interface flip_decision_unit_if #(
    parameter int unsigned N = flip_pkg::DefN,
    parameter int unsigned M = flip_pkg::DefM
);
    localparam int unsigned CntW = flip_pkg::cnt_w(N);

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a       [M];
    logic [N-1:0]   sa_mask [M];
    logic [N-1:0]   sa_val  [M];
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   a_q     [M];
    logic           f       [M];
`ifdef FLIP_DECISION_PATCH_COUNT_EN
    logic [CntW-1:0] resid  [M];
    logic            uncorrectable;
`endif

    modport master (
        output in_valid, a, sa_mask, sa_val, out_ready,
        input  in_ready, out_valid, a_q, f
`ifdef FLIP_DECISION_PATCH_COUNT_EN
        , input resid, uncorrectable
`endif
    );

    modport slave (
        input  in_valid, a, sa_mask, sa_val, out_ready,
        output in_ready, out_valid, a_q, f
`ifdef FLIP_DECISION_PATCH_COUNT_EN
        , output resid, uncorrectable
`endif
    );

endinterface

// File: rtl/flip_popcount.sv
// Combinational population count of an N-bit vector.
module flip_popcount
    import flip_pkg::*;
#(
    parameter int unsigned N = DefN
) (
    input  logic [N-1:0]          i_vec,
    output logic [cnt_w(N)-1:0]   o_cnt
);
    localparam int unsigned CntW = cnt_w(N);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < N; i++) begin
            o_cnt = o_cnt + CntW'(i_vec[i]);
        end
    end

endmodule

// File: rtl/flip_decision_unit.sv
// Decides per-word inversion flags against a stuck-at fault map, one word per cycle.
// Optional residual-mismatch reporting is enabled by FLIP_DECISION_PATCH_COUNT_EN.
module flip_decision_unit
    import flip_pkg::*;
#(
    parameter int unsigned N = DefN,
    parameter int unsigned M = DefM
`ifdef FLIP_DECISION_PATCH_COUNT_EN
    , parameter int unsigned PATCH_CAP = DefPatchCap
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    flip_decision_unit_if.slave  bus
);
    localparam int unsigned CntW = cnt_w(N);
    localparam int unsigned IdxW = (M > 1) ? $clog2(M) : 1;

    state_e          r_state;
    state_e          w_state_next;
    logic [IdxW-1:0] r_idx;
    logic [N-1:0]    r_a    [M];
    logic [N-1:0]    r_mask [M];
    logic [N-1:0]    r_val  [M];
    logic            r_f    [M];

    logic            w_accept;
    logic            w_last;
    logic [N-1:0]    w_diff;
    logic [CntW-1:0] w_mis;
    logic [CntW-1:0] w_tot;
    logic            w_flip;

`ifdef FLIP_DECISION_PATCH_COUNT_EN
    logic [CntW-1:0] r_resid [M];
    logic            r_unc;
    logic [CntW-1:0] w_res;
`endif

    // ---------------------------------------------------------------- control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_accept = (r_state == StIdle) && bus.in_valid;
    assign w_last   = (r_idx == IdxW'(M - 1));

    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = StScan;
                end
            end
            StScan: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // --------------------------------------------------------------- decision
    assign w_diff = r_mask[r_idx] & (r_a[r_idx] ^ r_val[r_idx]);

    flip_popcount #(
        .N (N)
    ) u_pop_mis (
        .i_vec (w_diff),
        .o_cnt (w_mis)
    );

    flip_popcount #(
        .N (N)
    ) u_pop_tot (
        .i_vec (r_mask[r_idx]),
        .o_cnt (w_tot)
    );

    // 2*mis compared one bit wider so mis == N cannot overflow; a tie keeps f = 0
    assign w_flip = {w_mis, 1'b0} > {1'b0, w_tot};

`ifdef FLIP_DECISION_PATCH_COUNT_EN
    assign w_res = w_flip ? (w_tot - w_mis) : w_mis;
`endif

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            for (int i = 0; i < M; i++) begin
                r_a[i]    <= '0;
                r_mask[i] <= '0;
                r_val[i]  <= '0;
                r_f[i]    <= 1'b0;
`ifdef FLIP_DECISION_PATCH_COUNT_EN
                r_resid[i] <= '0;
`endif
            end
`ifdef FLIP_DECISION_PATCH_COUNT_EN
            r_unc <= 1'b0;
`endif
        end else if (w_accept) begin
            r_idx <= '0;
            for (int i = 0; i < M; i++) begin
                r_a[i]    <= bus.a[i];
                r_mask[i] <= bus.sa_mask[i];
                r_val[i]  <= bus.sa_val[i];
                r_f[i]    <= 1'b0;
`ifdef FLIP_DECISION_PATCH_COUNT_EN
                r_resid[i] <= '0;
`endif
            end
`ifdef FLIP_DECISION_PATCH_COUNT_EN
            r_unc <= 1'b0;
`endif
        end else if (r_state == StScan) begin
            r_f[r_idx] <= w_flip;
`ifdef FLIP_DECISION_PATCH_COUNT_EN
            r_resid[r_idx] <= w_res;
            r_unc          <= r_unc | (32'(w_res) > PATCH_CAP);
`endif
            // idx parks at M-1 until the next accept
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        for (int i = 0; i < M; i++) begin
            bus.a_q[i] = r_a[i];
            bus.f[i]   = r_f[i];
`ifdef FLIP_DECISION_PATCH_COUNT_EN
            bus.resid[i] = r_resid[i];
`endif
        end
    end

`ifdef FLIP_DECISION_PATCH_COUNT_EN
    assign bus.uncorrectable = r_unc;
`endif

endmodule

// File: tb/tb_flip_decision_unit.sv
// Self-checking bench for flip_decision_unit: directed word table plus reset,
// back-pressure and back-to-back sequences.
module tb_flip_decision_unit;
    localparam int unsigned N  = 16;
    localparam int unsigned M  = 16;
    localparam int unsigned CW = $clog2(N + 1);

    typedef struct {
        logic [N-1:0]  a;
        logic [N-1:0]  mask;
        logic [N-1:0]  val;
        logic          exp_f;
        logic [CW-1:0] exp_res;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    vec_t         tbl    [M];
    logic [N-1:0] snap_a [M];
    logic [M-1:0] snap_f;

    flip_decision_unit_if #(.N(N), .M(M)) bus ();

    flip_decision_unit #(
        .N (N),
        .M (M)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [M-1:0] pack_f();
        logic [M-1:0] v;
        for (int i = 0; i < M; i++) v[i] = bus.f[i];
        return v;
    endfunction

    function automatic logic model_f(input logic [N-1:0] a, m, v);
        int mis = $countones(m & (a ^ v));
        int tot = $countones(m);
        return (2 * mis) > tot;
    endfunction

    // Drive in_valid until accepted; returns the cycle count seen just after the accept edge.
    task automatic offer(output int acc);
        int n = 0;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL offer: in_ready stayed 0, expected 1");
        end
        @(negedge clk);
        acc = cyc;
        bus.in_valid = 1'b0;
        check("in_ready after accept", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_out(input int acc, input string name);
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 32'(cyc - acc), 32'(M));
    endtask

    task automatic load_tbl();
        for (int i = 0; i < M; i++) begin
            bus.a[i]       = tbl[i].a;
            bus.sa_mask[i] = tbl[i].mask;
            bus.sa_val[i]  = tbl[i].val;
        end
    endtask

    initial begin
        int acc;
        int prev_acc;
        int bad;

        //            a         mask      val      f     res
        tbl[0]  = '{16'h0000, 16'h000F, 16'h000F, 1'b1, 5'd0};
        tbl[1]  = '{16'hFFFF, 16'h0000, 16'h1234, 1'b0, 5'd0};
        tbl[2]  = '{16'h0000, 16'h0003, 16'h0001, 1'b0, 5'd1};
        tbl[3]  = '{16'h0F0F, 16'hFFFF, 16'h00FF, 1'b0, 5'd8};
        tbl[4]  = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 5'd0};
        tbl[5]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 5'd0};
        tbl[6]  = '{16'h0070, 16'h00F0, 16'h0000, 1'b1, 5'd1};
        tbl[7]  = '{16'h0300, 16'h0F00, 16'h0F00, 1'b0, 5'd2};
        tbl[8]  = '{16'h8000, 16'h8001, 16'h0000, 1'b0, 5'd1};
        tbl[9]  = '{16'h0005, 16'h0007, 16'h0002, 1'b1, 5'd0};
        tbl[10] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 5'd0};
        tbl[11] = '{16'h0000, 16'h0001, 16'h0000, 1'b0, 5'd0};
        tbl[12] = '{16'h0003, 16'h001F, 16'h0000, 1'b0, 5'd2};
        tbl[13] = '{16'h0007, 16'h001F, 16'h0000, 1'b1, 5'd2};
        tbl[14] = '{16'hFFFF, 16'hFF00, 16'h0000, 1'b1, 5'd0};
        tbl[15] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 5'd0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        load_tbl();

        // reset state
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset f", 32'(pack_f()), 32'd0);
        bad = 0;
        for (int i = 0; i < M; i++) if (bus.a_q[i] != '0) bad++;
        check("reset a_q nonzero words", 32'(bad), 32'd0);
`ifdef FLIP_DECISION_PATCH_COUNT_EN
        check("reset uncorrectable", 32'(bus.uncorrectable), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // directed table block, consumer stalled
        offer(acc);
        wait_out(acc, "table");
        for (int i = 0; i < M; i++) begin
            check($sformatf("table f[%0d]", i), 32'(bus.f[i]), 32'(tbl[i].exp_f));
            check($sformatf("table a_q[%0d]", i), 32'(bus.a_q[i]), 32'(tbl[i].a));
`ifdef FLIP_DECISION_PATCH_COUNT_EN
            check($sformatf("table resid[%0d]", i), 32'(bus.resid[i]), 32'(tbl[i].exp_res));
`endif
        end
`ifdef FLIP_DECISION_PATCH_COUNT_EN
        check("table uncorrectable", 32'(bus.uncorrectable), 32'd1);
`endif

        // back-pressure: outputs hold and a second offer is ignored
        for (int i = 0; i < M; i++) snap_a[i] = tbl[i].a;
        for (int i = 0; i < M; i++) snap_f[i] = tbl[i].exp_f;
        for (int i = 0; i < M; i++) bus.a[i] = ~tbl[i].a;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bad = 0;
            for (int i = 0; i < M; i++) if (bus.a_q[i] !== snap_a[i]) bad++;
            check($sformatf("stall a_q moved words c%0d", c), 32'(bad), 32'd0);
            check($sformatf("stall f c%0d", c), 32'(pack_f()), 32'(snap_f));
            check($sformatf("stall out_valid c%0d", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall in_ready c%0d", c), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release in_ready", 32'(bus.in_ready), 32'd1);
        check("release out_valid", 32'(bus.out_valid), 32'd0);

        // all-clean block clears the sticky flag
        for (int i = 0; i < M; i++) begin
            bus.a[i]       = 16'hA5A5;
            bus.sa_mask[i] = '0;
            bus.sa_val[i]  = '0;
        end
        offer(acc);
        wait_out(acc, "clean");
        check("clean f", 32'(pack_f()), 32'd0);
`ifdef FLIP_DECISION_PATCH_COUNT_EN
        check("clean uncorrectable", 32'(bus.uncorrectable), 32'd0);
`endif
        @(negedge clk);

        // reset while scanning at idx=5
        for (int i = 0; i < M; i++) begin
            bus.a[i]       = 16'hFFFF;
            bus.sa_mask[i] = 16'hFFFF;
            bus.sa_val[i]  = 16'h0000;
        end
        offer(acc);
        repeat (5) @(negedge clk);
        check("midscan f[4] set", 32'(bus.f[4]), 32'd1);
        check("midscan out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst midscan out_valid", 32'(bus.out_valid), 32'd0);
        check("rst midscan in_ready", 32'(bus.in_ready), 32'd1);
        check("rst midscan f", 32'(pack_f()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        offer(acc);
        wait_out(acc, "post-reset");
        check("post-reset f", 32'(pack_f()), 32'hFFFF);
        @(negedge clk);

        // back-to-back random blocks, out_ready held high
        prev_acc = 0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < M; i++) begin
                bus.a[i]       = 16'($urandom);
                bus.sa_mask[i] = 16'($urandom);
                bus.sa_val[i]  = 16'($urandom);
                snap_a[i]      = bus.a[i];
                snap_f[i]      = model_f(bus.a[i], bus.sa_mask[i], bus.sa_val[i]);
            end
            offer(acc);
            if (b > 0) check($sformatf("b2b spacing b%0d", b), 32'(acc - prev_acc), 32'(M + 2));
            prev_acc = acc;
            wait_out(acc, $sformatf("b2b b%0d", b));
            check($sformatf("b2b f b%0d", b), 32'(pack_f()), 32'(snap_f));
            bad = 0;
            for (int i = 0; i < M; i++) if (bus.a_q[i] !== snap_a[i]) bad++;
            check($sformatf("b2b a_q wrong words b%0d", b), 32'(bad), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flip_decision_unit.md
# flip_decision_unit

- Sequential stage directly upstream of the flipping mechanism block.
- Takes a block of M data words plus the stuck-at fault map of the target memory rows, and decides one flip flag per word: invert the word when that leaves fewer stuck-at mismatches.
- Scans one word per cycle, then presents the registered words and flags together under a valid/ready handshake.
- Optionally reports the residual mismatches the downstream patch logic must cover.

## Interface
- N, 16, word width in bits
- M, 16, words per block
- PATCH_CAP, 2, residual mismatches per word the patch stage can absorb (only used with the macro)

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  block offered
- in_ready  out  1  block accepted when in_valid && in_ready
- a  in  [N-1:0] x [M-1:0] unpacked  data words
- sa_mask  in  [N-1:0] x [M-1:0]  1 = cell stuck
- sa_val  in  [N-1:0] x [M-1:0]  stuck value of that cell
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- a_q  out  [N-1:0] x [M-1:0]  registered copy of a; feeds the flipping block's a
- f  out  1 x [M-1:0] unpacked  flip flags; feeds the flipping block's f
- resid  out  [$clog2(N+1)-1:0] x [M-1:0]  residual mismatches per word (macro only)
- uncorrectable  out  1  some word has resid > PATCH_CAP (macro only)

## Operation
- **FSM states**
  - IDLE: in_ready=1. On accept, latch a, sa_mask and sa_val. Clear all f. Set idx=0. Go to SCAN.
  - SCAN: evaluate word idx, write f[idx], then idx++. When idx==M-1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
  - No other transitions. Illegal state encodings go to IDLE.
- **Per-word rule**
  - mis = popcount(sa_mask & (a ^ sa_val))
  - tot = popcount(sa_mask)
  - f = (2*mis > tot). A tie does not flip.
  - res = f ? tot−mis : mis
- **Width rules**
  - Counts are $clog2(N+1) bits.
  - The comparison is done at $clog2(N+1)+1 bits, so there is no overflow when mis=N.
  - idx is $clog2(M) bits (at least 1). It never wraps past M-1.
- **Output stability**
  - a_q, f and resid change only in IDLE (on accept) and in SCAN.
  - They are stable for the whole of DONE.
- **Boundary behaviour**
  - in_valid while not in IDLE is ignored (in_ready=0). There is no queue.
  - out_ready outside DONE is ignored.
  - M=1: SCAN lasts exactly one cycle.
  - Reset mid-scan: everything returns to reset values immediately. The partial block is discarded.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, all a_q=0, all f=0, all resid=0, uncorrectable=0, idx=0.
- **Latency:** accept on edge t → out_valid high after edge t+M.
- **Handshake:** result consumed on the first edge with out_valid && out_ready; in_ready rises on the next cycle.
- **Throughput:** one block per M+2 cycles when out_ready is held high.
- **in_ready** is combinational from state only. It never depends on in_valid.

## Configuration
- Macro: FLIP_DECISION_PATCH_COUNT_EN.
- **Defined:**
  - resid and uncorrectable ports exist.
  - resid[idx] is written in SCAN.
  - uncorrectable is a sticky OR over the block: cleared on accept, valid in DONE.
- **Undefined:**
  - Ports and registers are absent.
  - f and timing are identical to the defined build.

## Structure
- Package flip_pkg holds:
  - the state enum (IDLE, SCAN, DONE)
  - the count-width function cnt_w(N) = $clog2(N+1)
  - the default parameter constants shared with the flipping block
- One sub-module, flip_popcount #(N): combinational popcount of an N-bit vector. Instantiated twice, for mis and tot.

## Test plan
- **Reset mid-SCAN:** start a block, assert rst_n=0 at idx=5 → out_valid=0, in_ready=1, f all 0. The next block processes normally.
- **Majority flip:** word0 sa_mask=0x000F, sa_val=0x000F, a=0x0000 → f[0]=1, resid[0]=0. A word with mask=0 → f=0.
- **Tie:** mask=0x0003, sa_val=0x0001, a=0x0000 (mis=1, tot=2) → f=0, resid=1.
- **Latency and back-pressure:**
  - in_valid at edge 10 → out_valid after edge 26 (M=16).
  - Hold out_ready=0 for 5 cycles → a_q and f stable; second in_valid ignored.
  - out_ready=1 → in_ready=1 next cycle.
- **Uncorrectable (macro on):** mask=0xFFFF, sa_val=0x00FF, a=0x0F0F (mis=8, tot=16) → f=0, resid=8, uncorrectable=1. Next block all-clean → uncorrectable=0.
- **Back-to-back:** random blocks with out_ready=1 → spacing of M+2 cycles. f matches a reference model word-for-word, and a_q equals the captured a.
